// File: rtl/frame_sched_if.sv
// Bundles the coordinate, sensor, button and strobe signals of frame_sched.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is sampled or produced once per pixel_clk.
//
// Ports:
//   master : upstream side; drives coordinates, accel, buttons and collision,
//            and observes the scheduler outputs.
//   slave  : the scheduler itself.
interface frame_sched_if;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic [7:0]  accel_data_x;
    logic [7:0]  accel_data_y;
    logic        button_c;
    logic        button_d;
    logic        collision;
    logic [7:0]  accel_x_end_of_frame;
    logic [7:0]  accel_y_end_of_frame;
    logic        end_of_frame;
    logic        update_en;
    logic        game_restart;
    logic        blink;
    logic [15:0] frame_cnt;
    logic [1:0]  regime_status;

    modport master (
        output h_coord, v_coord, accel_data_x, accel_data_y,
               button_c, button_d, collision,
        input  accel_x_end_of_frame, accel_y_end_of_frame, end_of_frame,
               update_en, game_restart, blink, frame_cnt, regime_status
    );

    modport slave (
        input  h_coord, v_coord, accel_data_x, accel_data_y,
               button_c, button_d, collision,
        output accel_x_end_of_frame, accel_y_end_of_frame, end_of_frame,
               update_en, game_restart, blink, frame_cnt, regime_status
    );
endinterface

// File: rtl/frame_sched.sv
// Frame-synchronous game scheduler: end-of-frame detect, accel freeze, regime FSM.
// Latency: end_of_frame and frozen accel 1 cycle after the last active pixel; state/strobes 1 cycle later.
// Backpressure: none; button presses are held in sticky flags until the next end_of_frame.
//
// Ports:
//   pixel_clk, rst_n : clock and asynchronous active-low reset
//   bus (slave)      : coordinates, live accel, buttons, collision in;
//                      frozen accel, end_of_frame, update_en, game_restart,
//                      blink, frame_cnt, regime_status out
module frame_sched #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int OVER_HOLD = 180,
    parameter int BLINK_DIV = 32
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    frame_sched_if.slave  bus
);

    localparam int          BLINK_BIT = $clog2(BLINK_DIV);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE - 1);
    localparam logic [15:0] OVER_LAST = 16'(OVER_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        eof_cond;
    logic        eof_q;
    logic [7:0]  accel_x_q;
    logic [7:0]  accel_y_q;
    logic        button_c_d;
    logic        button_d_d;
    logic        c_pending;
    logic        d_pending;
    logic        c_press;
    logic        d_press;
    logic        c_cmd;
    logic        d_cmd;
    logic [15:0] frame_cnt_q;
    logic        update_q;
    logic        restart_q;

    assign eof_cond = (bus.h_coord == H_LAST) && (bus.v_coord == V_LAST);

    assign c_press = bus.button_c & ~button_c_d;
    assign d_press = bus.button_d & ~button_d_d;

    // A press landing exactly in the end_of_frame cycle is folded into this
    // frame's command rather than lost when the pending flags clear.
    assign c_cmd = c_pending | c_press;
    assign d_cmd = d_pending | d_press;

    // Front end: frame boundary, accel freeze, button edge capture.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            eof_q      <= 1'b0;
            accel_x_q  <= 8'h00;
            accel_y_q  <= 8'h00;
            button_c_d <= 1'b0;
            button_d_d <= 1'b0;
            c_pending  <= 1'b0;
            d_pending  <= 1'b0;
        end else begin
            eof_q      <= eof_cond;
            button_c_d <= bus.button_c;
            button_d_d <= bus.button_d;
            // Loading on eof_cond makes the new value visible together with
            // the end_of_frame pulse on the following cycle.
            if (eof_cond) begin
                accel_x_q <= bus.accel_data_x;
                accel_y_q <= bus.accel_data_y;
            end
            if (eof_q) begin
                c_pending <= 1'b0;
                d_pending <= 1'b0;
            end else begin
                c_pending <= c_pending | c_press;
                d_pending <= d_pending | d_press;
            end
        end
    end

    // Transition decision; only applied in the end_of_frame cycle.
    // Priority everywhere: abort, then collision, then start/pause.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (c_cmd) state_nxt = PLAY;
            end
            PLAY: begin
                if (d_cmd)              state_nxt = IDLE;
                else if (bus.collision) state_nxt = OVER;
                else if (c_cmd)         state_nxt = PAUSE;
            end
            PAUSE: begin
                if (d_cmd)      state_nxt = IDLE;
                else if (c_cmd) state_nxt = PLAY;
            end
            OVER: begin
                if (d_cmd || c_cmd)              state_nxt = IDLE;
                else if (frame_cnt_q == OVER_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Regime FSM with registered strobes and frame counter.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_cnt_q <= 16'h0000;
            update_q    <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            update_q  <= 1'b0;
            restart_q <= 1'b0;
            if (eof_q) begin
                state <= state_nxt;
                if (state_nxt != state) begin
                    frame_cnt_q <= 16'h0000;
                end else if (frame_cnt_q != 16'hFFFF) begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                end
                // A restart frame never advances the game, so the two
                // strobes are mutually exclusive by construction.
                update_q  <= (state == PLAY) && (state_nxt == PLAY);
                restart_q <= (state == IDLE) && (state_nxt == PLAY);
            end
        end
    end

    assign bus.end_of_frame         = eof_q;
    assign bus.accel_x_end_of_frame = accel_x_q;
    assign bus.accel_y_end_of_frame = accel_y_q;
    assign bus.update_en            = update_q;
    assign bus.game_restart         = restart_q;
    assign bus.frame_cnt            = frame_cnt_q;
    assign bus.regime_status        = state;
    assign bus.blink                = (state == PAUSE) & frame_cnt_q[BLINK_BIT];

endmodule

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Frame-synchronous scheduler for the game datapath on pixel_clk.
- Detects the end of each active frame from the pixel coordinates.
- Freezes accelerometer samples once per frame, so game logic and the 7-seg display see stable values.
- Runs the game-regime state machine (IDLE/PLAY/PAUSE/OVER) from button edges, and issues per-frame update and restart strobes to the game logic.

Parameters:
H_ACTIVE, 800, visible pixels per line
V_ACTIVE, 600, visible lines per frame
OVER_HOLD, 180, frames OVER is held before auto-return to IDLE
BLINK_DIV, 32, frames per half-period of the pause blink (power of 2)

Ports:
pixel_clk  in  1  pixel clock (36 MHz)
rst_n  in  1  asynchronous active-low reset
h_coord  in  11  current horizontal pixel coordinate
v_coord  in  10  current vertical pixel coordinate
accel_data_x  in  8  live accelerometer X (already in pixel_clk domain)
accel_data_y  in  8  live accelerometer Y
button_c  in  1  debounced level, start/pause
button_d  in  1  debounced level, abort to IDLE
collision  in  1  level from game logic, player hit
accel_x_end_of_frame  out  8  X value frozen at last end-of-frame
accel_y_end_of_frame  out  8  Y value frozen at last end-of-frame
end_of_frame  out  1  1-cycle pulse after last active pixel
update_en  out  1  1-cycle pulse; game logic advances one step
game_restart  out  1  1-cycle pulse; game logic reloads initial state
blink  out  1  pause blink phase
frame_cnt  out  16  frames since entering current state, saturating
regime_status  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, state IDLE, internal edge registers 0. Reset may assert at any cycle; pulses in flight are dropped.
- Coordinate terms: eof_cond = (h_coord==H_ACTIVE-1 && v_coord==V_ACTIVE-1), registered once.
- end_of_frame: 1-cycle pulse one cycle after eof_cond; fires exactly once per frame.
- Accelerometer latch: on the same cycle as end_of_frame, accel_*_end_of_frame load the accel_data_* values sampled in the eof_cond cycle. They hold otherwise. They update in every state.
- Button edges: press = level & ~level_d, using a registered previous level. Edges are acted on only at end_of_frame. A press seen mid-frame is stored in a sticky pending flag. The flag clears at end_of_frame, so at most one command is applied per frame.
- collision is sampled at end_of_frame only.
- FSM transitions, evaluated only in the end_of_frame cycle:
  - Priority: d_pending > collision > c_pending.
  - IDLE: c_pending -> PLAY; also assert game_restart.
  - PLAY: d_pending -> IDLE; collision -> OVER; c_pending -> PAUSE.
  - PAUSE: d_pending -> IDLE; c_pending -> PLAY. collision is ignored.
  - OVER: d_pending or c_pending -> IDLE. When frame_cnt reaches OVER_HOLD-1 at end_of_frame -> IDLE.
- Strobe timing:
  - update_en pulses the cycle after end_of_frame when the state was PLAY at end_of_frame and no transition left PLAY in that cycle.
  - game_restart pulses in the same cycle as the IDLE->PLAY state change.
  - update_en and game_restart are never high together: a restart frame has no update.
- frame_cnt: cleared on any state change; otherwise +1 per end_of_frame, saturating at 16'hFFFF (no wrap).
- blink: 0 outside PAUSE. In PAUSE it toggles every BLINK_DIV frames, i.e. it is frame_cnt bit log2(BLINK_DIV).
- regime_status equals the state encoding and is registered.

Test Plan:
- Reset with rst_n=0 mid-frame, release, then sweep a full 1024x625 raster -> all outputs 0 until the first end_of_frame; end_of_frame pulses exactly once, at (799,599)+1 cycle.
- accel_data_x=8'h12 at the eof_cond cycle, 8'h34 one cycle later -> accel_x_end_of_frame=8'h12, held through the next frame.
- From IDLE, press button_c at line 100 -> at end_of_frame regime_status=01 and game_restart pulses once; update_en stays 0 for that frame and pulses once on each subsequent frame.
- In PLAY, assert collision and a button_c press in the same frame -> state OVER (11), not PAUSE; no update_en; return to IDLE after 180 frames with no input.
- In PAUSE, run 64 frames -> blink toggles at frame 32 and 64; update_en stays 0 throughout; button_d press -> IDLE with frame_cnt=0.
- Two button_c presses within one frame in IDLE -> only one transition (to PLAY); the second press is consumed and does not cause a PAUSE.
